// File: rtl/ecall_service_unit_if.sv
// Core-side link of the ecall service unit: decoder request and register-file write port.
interface ecall_service_unit_if;
    logic        ecall;
    logic [31:0] a7_val;
    logic [31:0] a0_val;
    logic        stall;
    logic        wb_en;
    logic [4:0]  wb_sel;
    logic [31:0] wb_data;

    modport master (output ecall, a7_val, a0_val, input stall, wb_en, wb_sel, wb_data);
    modport slave  (input ecall, a7_val, a0_val, output stall, wb_en, wb_sel, wb_data);
endinterface

// File: rtl/ecall_service_unit.sv
// Services ecall syscalls (print int, read int, print char, exit) while stalling the core.
// state    | meaning
// IDLE     | no service in progress; stall follows ecall
// WAIT_ACK | a0 shown on 7-seg, waiting for operator press
// WAIT_RD  | waiting for press to sample switches into x10
// DONE     | release stall for one cycle so the PC steps past the ecall
// HALT     | exit reached; core frozen until reset
module ecall_service_unit #(
    parameter int SW_WIDTH = 16,
    parameter bit SIGN_EXT = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    ecall_service_unit_if.slave     core,
    input  logic                    confirm_btn,
    input  logic [SW_WIDTH-1:0]     switches,
    output logic [31:0]             seg_value,
    output logic                    seg_valid,
    output logic [7:0]              led_out,
    output logic                    halted
);
    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_ACK, S_WAIT_RD, S_DONE, S_HALT
    } state_t;

    state_t      state_q, state_d;
    logic        btn_q, btn_d;
    logic        wb_en_q, wb_en_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic [31:0] seg_value_q, seg_value_d;
    logic        seg_valid_q, seg_valid_d;
    logic [7:0]  led_out_q, led_out_d;
    logic        halted_q, halted_d;
    logic        stall_c;
    logic        press;
    logic [31:0] sw_ext;

    // Only a fresh rising edge counts; a button already held on entry is ignored.
    assign press  = confirm_btn & ~btn_q;
    assign sw_ext = SIGN_EXT ? 32'($signed(switches)) : 32'(switches);

    always_comb begin
        state_d     = state_q;
        btn_d       = confirm_btn;
        wb_en_d     = 1'b0;
        wb_data_d   = wb_data_q;
        seg_value_d = seg_value_q;
        seg_valid_d = seg_valid_q;
        led_out_d   = led_out_q;
        halted_d    = halted_q;
        stall_c     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                stall_c = core.ecall;
                if (core.ecall) begin
                    unique case (core.a7_val)
                        32'd1: begin
                            seg_value_d = core.a0_val;
                            seg_valid_d = 1'b1;
                            state_d     = S_WAIT_ACK;
                        end
                        32'd5:  state_d = S_WAIT_RD;
                        32'd11: begin
                            led_out_d = core.a0_val[7:0];
                            state_d   = S_DONE;
                        end
                        32'd10: begin
                            halted_d = 1'b1;
                            state_d  = S_HALT;
                        end
                        default: state_d = S_DONE;
                    endcase
                end
            end
            S_WAIT_ACK: begin
                stall_c = 1'b1;
                if (press) begin
                    seg_valid_d = 1'b0;
                    state_d     = S_DONE;
                end
            end
            S_WAIT_RD: begin
                stall_c = 1'b1;
                if (press) begin
                    wb_data_d = sw_ext;
                    wb_en_d   = 1'b1;
                    state_d   = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_HALT:  stall_c = 1'b1;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        btn_q <= btn_d;
        if (!rst_n) begin
            state_q     <= S_IDLE;
            wb_en_q     <= 1'b0;
            wb_data_q   <= 32'd0;
            seg_value_q <= 32'd0;
            seg_valid_q <= 1'b0;
            led_out_q   <= 8'd0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            wb_en_q     <= wb_en_d;
            wb_data_q   <= wb_data_d;
            seg_value_q <= seg_value_d;
            seg_valid_q <= seg_valid_d;
            led_out_q   <= led_out_d;
            halted_q    <= halted_d;
        end
    end

    assign core.stall   = rst_n & stall_c;
    assign core.wb_en   = wb_en_q;
    assign core.wb_sel  = 5'd10;
    assign core.wb_data = wb_data_q;
    assign seg_value    = seg_value_q;
    assign seg_valid    = seg_valid_q;
    assign led_out      = led_out_q;
    assign halted       = halted_q;
endmodule

// File: tb/tb_ecall_service_unit.sv
// Directed bench for ecall_service_unit: sign- and zero-extending instances share one stimulus.
module tb_ecall_service_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        ecall;
    logic [31:0] a7, a0;
    logic        btn;
    logic [15:0] sw;

    logic [31:0] seg_value_s, seg_value_z;
    logic        seg_valid_s, seg_valid_z;
    logic [7:0]  led_s, led_z;
    logic        halted_s, halted_z;

    int n_chk  = 0;
    int n_fail = 0;
    logic [31:0] exp_s_q[$];
    logic [31:0] exp_z_q[$];
    int bad;

    ecall_service_unit_if bus_s ();
    ecall_service_unit_if bus_z ();

    assign bus_s.ecall  = ecall;
    assign bus_s.a7_val = a7;
    assign bus_s.a0_val = a0;
    assign bus_z.ecall  = ecall;
    assign bus_z.a7_val = a7;
    assign bus_z.a0_val = a0;

    always #5 clk = ~clk;

    ecall_service_unit #(.SW_WIDTH(16), .SIGN_EXT(1'b1)) dut_s (
        .clk(clk), .rst_n(rst_n), .core(bus_s.slave), .confirm_btn(btn), .switches(sw),
        .seg_value(seg_value_s), .seg_valid(seg_valid_s), .led_out(led_s), .halted(halted_s));

    ecall_service_unit #(.SW_WIDTH(16), .SIGN_EXT(1'b0)) dut_z (
        .clk(clk), .rst_n(rst_n), .core(bus_z.slave), .confirm_btn(btn), .switches(sw),
        .seg_value(seg_value_z), .seg_valid(seg_valid_z), .led_out(led_z), .halted(halted_z));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pop_wb(input string tag);
        if (exp_s_q.size() == 0 || exp_z_q.size() == 0) begin
            chk({tag, "_queue_empty"}, 32'(exp_s_q.size() + exp_z_q.size()), 32'd2);
        end else begin
            chk({tag, "_sext"}, bus_s.wb_data, exp_s_q.pop_front());
            chk({tag, "_zext"}, bus_z.wb_data, exp_z_q.pop_front());
        end
    endtask

    initial begin
        rst_n = 1'b0; ecall = 1'b1; a7 = 32'd1; a0 = 32'h1234_5678; btn = 1'b0; sw = 16'h0;
        #1;
        chk("stall_forced_in_reset", {31'd0, bus_s.stall}, 32'd0);
        step();
        chk("reset_seg_valid", {31'd0, seg_valid_s}, 32'd0);
        ecall = 1'b0; rst_n = 1'b1;
        step();
        chk("reset_wb_en",     {31'd0, bus_s.wb_en}, 32'd0);
        chk("reset_wb_data",   bus_s.wb_data, 32'd0);
        chk("reset_seg_value", seg_value_s, 32'd0);
        chk("reset_led",       {24'd0, led_s}, 32'd0);
        chk("reset_halted",    {31'd0, halted_s}, 32'd0);
        chk("reset_stall",     {31'd0, bus_s.stall}, 32'd0);

        // print int: hold for 50 cycles, release on press
        a7 = 32'd1; a0 = 32'hDEAD_BEEF; ecall = 1'b1;
        exp_s_q.push_back(32'hDEAD_BEEF);
        #1;
        chk("pint_idle_stall", {31'd0, bus_s.stall}, 32'd1);
        step();
        chk("pint_seg_valid", {31'd0, seg_valid_s}, 32'd1);
        if (exp_s_q.size() != 0) chk("pint_seg_value", seg_value_s, exp_s_q.pop_front());
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            if (bus_s.stall !== 1'b1 || seg_valid_s !== 1'b1 || bus_s.wb_en !== 1'b0) bad++;
            step();
        end
        chk("pint_hold_50", 32'(bad), 32'd0);
        btn = 1'b1;
        step();
        chk("pint_ack_stall", {31'd0, bus_s.stall}, 32'd0);
        chk("pint_ack_valid", {31'd0, seg_valid_s}, 32'd0);
        chk("pint_seg_keep",  seg_value_s, 32'hDEAD_BEEF);
        chk("pint_no_wb",     {31'd0, bus_s.wb_en}, 32'd0);
        ecall = 1'b0; btn = 1'b0;
        step();
        chk("pint_back_idle", {31'd0, bus_s.stall}, 32'd0);

        // read int with sign/zero extension
        a7 = 32'd5; sw = 16'h8001; ecall = 1'b1;
        exp_s_q.push_back(32'hFFFF_8001);
        exp_z_q.push_back(32'h0000_8001);
        step();
        step();
        chk("rd_wait_stall", {31'd0, bus_s.stall}, 32'd1);
        chk("rd_wait_wb_en", {31'd0, bus_s.wb_en}, 32'd0);
        btn = 1'b1;
        step();
        chk("rd_wb_en",    {31'd0, bus_s.wb_en}, 32'd1);
        chk("rd_stall",    {31'd0, bus_s.stall}, 32'd0);
        chk("rd_wb_sel",   {27'd0, bus_s.wb_sel}, 32'd10);
        pop_wb("rd_data");
        ecall = 1'b0; btn = 1'b0;
        step();
        chk("rd_wb_en_one_cycle", {31'd0, bus_s.wb_en}, 32'd0);

        // button held before the ecall must not complete the read
        btn = 1'b1;
        step();
        a7 = 32'd5; sw = 16'h1234; ecall = 1'b1;
        step();
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (bus_s.wb_en !== 1'b0 || bus_s.stall !== 1'b1) bad++;
            step();
        end
        chk("held_no_complete", 32'(bad), 32'd0);
        btn = 1'b0;
        step();
        chk("held_release_wait", {31'd0, bus_s.stall}, 32'd1);
        sw = 16'hF00F;
        exp_s_q.push_back(32'hFFFF_F00F);
        exp_z_q.push_back(32'h0000_F00F);
        btn = 1'b1;
        step();
        chk("held_repress_wb_en", {31'd0, bus_s.wb_en}, 32'd1);
        pop_wb("held_data");
        ecall = 1'b0; btn = 1'b0;
        step();

        // print char followed by back-to-back no-op
        a7 = 32'd11; a0 = 32'h0000_0141; ecall = 1'b1;
        #1;
        chk("pchar_stall_idle", {31'd0, bus_s.stall}, 32'd1);
        step();
        chk("pchar_led",        {24'd0, led_s}, 32'h41);
        chk("pchar_done_stall", {31'd0, bus_s.stall}, 32'd0);
        chk("pchar_no_wb",      {31'd0, bus_s.wb_en}, 32'd0);
        a7 = 32'd99;
        step();
        chk("noop_idle_stall", {31'd0, bus_s.stall}, 32'd1);
        step();
        chk("noop_done_stall", {31'd0, bus_s.stall}, 32'd0);
        chk("noop_no_wb",      {31'd0, bus_s.wb_en}, 32'd0);
        chk("noop_led_keep",   {24'd0, led_s}, 32'h41);
        ecall = 1'b0;
        step();
        chk("noop_back_idle", {31'd0, bus_s.stall}, 32'd0);

        // exit: frozen until reset
        a7 = 32'd10; ecall = 1'b1;
        step();
        chk("halt_halted", {31'd0, halted_s}, 32'd1);
        chk("halt_stall",  {31'd0, bus_s.stall}, 32'd1);
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            ecall = i[0];
            btn   = i[1];
            a7    = (i % 3 == 0) ? 32'd5 : 32'd1;
            step();
            if (bus_s.stall !== 1'b1 || halted_s !== 1'b1 || bus_s.wb_en !== 1'b0 || seg_valid_s !== 1'b0) bad++;
        end
        chk("halt_sticky", 32'(bad), 32'd0);
        btn = 1'b0; ecall = 1'b0; rst_n = 1'b0;
        #1;
        chk("halt_reset_stall_forced", {31'd0, bus_s.stall}, 32'd0);
        step();
        rst_n = 1'b1;
        #1;
        chk("halt_cleared",        {31'd0, halted_s}, 32'd0);
        chk("halt_reset_stall",    {31'd0, bus_s.stall}, 32'd0);
        ecall = 1'b1; a7 = 32'd99;
        #1;
        chk("halt_reset_idle_ecall", {31'd0, bus_s.stall}, 32'd1);
        step();
        ecall = 1'b0;
        step();

        // reset while in WAIT_RD with a press on the same edge
        a7 = 32'd5; sw = 16'h7777; ecall = 1'b1;
        step();
        chk("rst_mid_wait", {31'd0, bus_s.stall}, 32'd1);
        rst_n = 1'b0; btn = 1'b1;
        step();
        rst_n = 1'b1; ecall = 1'b0;
        #1;
        chk("rst_mid_no_wb",    {31'd0, bus_s.wb_en}, 32'd0);
        chk("rst_mid_seg",      {31'd0, seg_valid_s}, 32'd0);
        chk("rst_mid_idle",     {31'd0, bus_s.stall}, 32'd0);
        chk("rst_mid_wb_data",  bus_s.wb_data, 32'd0);
        btn = 1'b0;
        step();
        chk("rst_mid_no_late_wb", {31'd0, bus_s.wb_en}, 32'd0);
        chk("queues_drained", 32'(exp_s_q.size() + exp_z_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
